fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 3, instruction address width (matches program counter output).
REQ-002 Parameter DATA_W, default 8, instruction word width.
REQ-003 Parameter TIMEOUT, default 15, max cycles in REQ without mem_ack before error; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  fetch enable; level-sensitive.
REQ-007 flush  input  1  abort current fetch (jump/redirect); level-sensitive.
REQ-008 pc  input  ADDR_W  current address from program counter.
REQ-009 pc_inc  output  1  one-cycle pulse commanding program counter to advance.
REQ-010 mem_req  output  1  instruction memory read request.
REQ-011 mem_addr  output  ADDR_W  address of outstanding request.
REQ-012 mem_ack  input  1  memory read complete; mem_data valid same cycle.
REQ-013 mem_data  input  DATA_W  instruction word from memory.
REQ-014 instr  output  DATA_W  fetched instruction to decoder.
REQ-015 instr_valid  output  1  instr holds a valid word.
REQ-016 instr_ready  input  1  decoder accepts instr this cycle.
REQ-017 fetch_err  output  1  one-cycle pulse on request timeout.

Function
REQ-018 FSM states IDLE, REQ, HOLD; exactly one active at all times.
REQ-019 IDLE: mem_req=0, instr_valid=0; if en=1 and flush=0, latch pc into mem_addr, next state REQ.
REQ-020 REQ: mem_req=1, mem_addr stable; on mem_ack=1 capture mem_data into instr, next state HOLD.
REQ-021 REQ: wait counter increments each cycle without mem_ack; when count reaches TIMEOUT, fetch_err pulses for one cycle, mem_req drops, next state IDLE, pc_inc not asserted (same address retried).
REQ-022 HOLD: instr_valid=1, instr and mem_addr stable until handshake; mem_req=0.
REQ-023 HOLD with instr_ready=1: pc_inc=1 that cycle, next state IDLE; pc_inc=0 in all other cycles.
REQ-024 Mandatory IDLE cycle after every handshake, so next fetch samples the advanced pc.
REQ-025 Minimum latency: en sampled in IDLE at cycle N, mem_ack at N+1, instr_valid=1 at N+2.
REQ-026 flush=1 in any state: next state IDLE, no pc_inc, no fetch_err, instr_valid=0 next cycle; flush overrides mem_ack, instr_ready and timeout in the same cycle.
REQ-027 mem_ack outside REQ is ignored; instr unchanged.
REQ-028 en deasserted in REQ or HOLD does not abort; takes effect only in IDLE.
REQ-029 pc wrap (2^ADDR_W-1 to 0) requires no special handling; address used verbatim.
REQ-030 Wait counter clears on entry to REQ; width ceil(log2(TIMEOUT+1)).

Reset
REQ-031 On rst=1 at a rising edge: state IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, pc_inc=0, fetch_err=0, wait counter=0.
REQ-032 rst takes priority over flush, en, mem_ack and instr_ready; reset mid-fetch discards the outstanding request with no pc_inc.

Structure
REQ-033 FSM state encoding and default ADDR_W/DATA_W constants in shared package cpu_ctrl_pkg, reused by program counter and decoder.
REQ-034 Timeout counter implemented as sub-module fetch_timeout_counter (inputs clr, inc; output expired).

Verification
REQ-035 Reset then en=1, pc=3, mem_ack one cycle after mem_req with mem_data=0xA5 -> mem_addr=3, instr=0xA5, instr_valid=1 two cycles after en; instr_ready=1 -> pc_inc single pulse.
REQ-036 instr_ready held 0 for 5 cycles in HOLD -> instr=0xA5 and instr_valid stable all 5 cycles, no pc_inc, mem_req=0.
REQ-037 TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, fetch_err one-cycle pulse, IDLE, re-request to same address.
REQ-038 flush=1 coincident with mem_ack in REQ -> instr_valid stays 0, no pc_inc, IDLE next cycle.
REQ-039 pc counts 6,7,0 with back-to-back handshakes -> mem_addr sequence 6,7,0, one pc_inc per fetch.
REQ-040 rst=1 while in HOLD -> all outputs at reset values next cycle, no pc_inc.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: fetch FSM encoding and default datapath widths.
package cpu_ctrl_pkg;

  localparam int unsigned DefAddrW = 3;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts request cycles that pass without a memory acknowledge.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Expiry is flagged on the cycle whose increment would reach TIMEOUT.
  assign expired = inc && (cnt_q == LastCnt);

  // Clear has priority; the FSM leaves the request state once expired fires.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding read, holds the word until the decoder accepts it.
module fetch_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

  fetch_state_e      state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              fetch_err_q;

  logic tmo_clr;
  logic tmo_inc;
  logic tmo_expired;

  // Counter only runs while a request is outstanding and unacknowledged.
  assign tmo_clr = (state_q != StReq) || flush;
  assign tmo_inc = (state_q == StReq) && !mem_ack && !flush;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  // pc_inc is decoded from the handshake itself so the PC advances on the same
  // edge that returns us to IDLE; the IDLE cycle then sees the new address.
  always_comb begin
    pc_inc = (state_q == StHold) && instr_ready && !flush && !rst;
  end

  // Fetch FSM with registered outputs; reset beats flush, which beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      fetch_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (en && !flush) begin
            mem_addr_q <= pc;
            mem_req_q  <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (flush) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end else if (mem_ack) begin
            instr_q       <= mem_data;
            instr_valid_q <= 1'b1;
            mem_req_q     <= 1'b0;
            state_q       <= StHold;
          end else if (tmo_expired) begin
            // Give up without advancing the PC so the same address is retried.
            fetch_err_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StHold: begin
          if (flush || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: begin
          mem_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
          state_q       <= StIdle;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a transaction model.
module tb_fetch_unit;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          pc_inc;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          fetch_err;

  int n_vec = 0;
  int n_bad = 0;

  // Model of the fetch contract: is a read pending, is a word waiting for the decoder.
  bit            m_pending = 0;
  bit            m_have = 0;
  bit            m_err = 0;
  int            m_waited = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_word = '0;
  logic [AW-1:0] pc_m = '0;

  fetch_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flush       (flush),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check pc_inc mid-cycle, advance model at posedge,
  // then check the registered outputs just after the edge.
  task automatic cycle(input bit r, input bit e, input bit f, input bit a, input bit rdy,
                       input logic [DW-1:0] d);
    bit exp_inc;
    @(negedge clk);
    rst = r; en = e; flush = f; mem_ack = a; instr_ready = rdy; mem_data = d; pc = pc_m;
    #1;
    exp_inc = m_have && rdy && !f && !r;
    check_eq("pc_inc", {31'b0, pc_inc}, {31'b0, exp_inc});
    @(posedge clk);
    m_err = 0;
    if (r) begin
      m_pending = 0; m_have = 0; m_waited = 0; m_addr = '0; m_word = '0;
    end else if (m_have) begin
      if (f || rdy) m_have = 0;
    end else if (m_pending) begin
      if (f) begin
        m_pending = 0;
      end else if (a) begin
        m_word = d; m_pending = 0; m_have = 1;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_pending = 0; m_err = 1;
        end
      end
    end else if (e && !f) begin
      m_pending = 1; m_waited = 0; m_addr = pc_m;
    end
    if (exp_inc) pc_m = pc_m + 1'b1;
    #1;
    check_eq("mem_req", {31'b0, mem_req}, {31'b0, m_pending});
    check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
    check_eq("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    check_eq("mem_addr", {29'b0, mem_addr}, {29'b0, m_addr});
    check_eq("instr", {24'b0, instr}, {24'b0, m_word});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    int err_cnt;
    int inc_cnt;
    logic [AW-1:0] want;

    // Reset values.
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(1, 1, 1, 1, 1, 8'hFF);
    check_eq("rst_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_instr", {24'b0, instr}, 32'd0);

    // Basic fetch from address 3, then hold with decoder stalled for 5 cycles.
    pc_m = 3'd3;
    cycle(0, 1, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 1, 0, 8'hA5);
    check_eq("d_instr", {24'b0, instr}, 32'hA5);
    check_eq("d_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("d_addr", {29'b0, mem_addr}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, i[0], 0, 8'h3C);
      check_eq("stall_instr", {24'b0, instr}, 32'hA5);
      check_eq("stall_req", {31'b0, mem_req}, 32'd0);
    end
    cycle(0, 0, 0, 0, 1, 8'h00);
    check_eq("pc_adv", {29'b0, pc_m}, 32'd4);
    cycle(0, 0, 0, 0, 0, 8'h00);

    // Timeout with no acknowledge.
    req_cnt = 0; err_cnt = 0;
    cycle(0, 1, 0, 0, 0, 8'h00);
    if (mem_req) req_cnt++;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0, 8'h00);
      if (mem_req) req_cnt++;
      if (fetch_err) err_cnt++;
    end
    check_eq("tmo_req_cycles", req_cnt, 32'd4);
    check_eq("tmo_err_pulses", err_cnt, 32'd1);
    cycle(0, 1, 0, 0, 0, 8'h00);
    check_eq("tmo_retry_addr", {29'b0, mem_addr}, 32'd4);

    // Flush coincident with acknowledge.
    cycle(0, 0, 1, 1, 0, 8'h77);
    check_eq("flush_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("flush_req", {31'b0, mem_req}, 32'd0);

    // Back-to-back fetches across the address wrap.
    pc_m = 3'd6; want = 3'd6; inc_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 0, 8'h00);
      check_eq("wrap_addr", {29'b0, mem_addr}, {29'b0, want});
      cycle(0, 1, 0, 1, 0, 8'h10 + k[7:0]);
      cycle(0, 1, 0, 0, 1, 8'h00);
      if (pc_m == want + 1'b1) inc_cnt++;
      want = want + 1'b1;
    end
    check_eq("wrap_incs", inc_cnt, 32'd3);

    // Reset while holding a word.
    cycle(0, 1, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 1, 0, 8'h5A);
    cycle(1, 1, 0, 0, 1, 8'h00);
    check_eq("hold_rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("hold_rst_instr", {24'b0, instr}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit r, f;
      r = ($urandom % 100) == 0;
      f = ($urandom % 16) == 0;
      if (f && ($urandom % 2)) pc_m = AW'($urandom);
      cycle(r, ($urandom % 4) != 0, f, ($urandom % 3) == 0, $urandom % 2, DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
